// File: rtl/mem_fill.sv
// mem_fill: parametrised RAM initialiser.
//
// On an accepted start request it writes the inclusive address range
// start_addr..end_addr (wrapping modulo 2^ADDR_W) at one word per
// non-stalled cycle. Data pattern per mode: 0 IDENTITY, 1 CONST, 2 RAMP,
// 3 LFSR (only when MEM_FILL_LFSR_EN is defined; otherwise mode 3 is
// rejected and the block stays idle).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   en                start request, honoured only while rdy=1
//   mode              pattern select, latched at start
//   start_addr        first address, latched at start
//   end_addr          last address (inclusive), latched at start
//   seed              constant / ramp origin / LFSR seed, latched at start
//   step              ramp increment, latched at start
//   stall             1 = current write not accepted this cycle
//   rdy               idle, can accept en
//   done              one-cycle pulse after the last accepted write
//   addr, wrdata      RAM write address and data (registered)
//   wren              RAM write strobe (registered)
//
// Build option: `define MEM_FILL_LFSR_EN to include the LFSR pattern.
module mem_fill #(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] step,
    input  logic              stall,
    output logic              rdy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren
);

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] step_q, step_d;
    logic [1:0]        mode_q, mode_d;
    logic              wren_q, wren_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;

    logic              mode_legal;
    logic [ADDR_W-1:0] addr_inc;
    logic [DATA_W-1:0] first_word;
    logic [DATA_W-1:0] next_word;

    assign addr_inc = addr_q + 1'b1;

`ifdef MEM_FILL_LFSR_EN
    assign mode_legal = 1'b1;
`else
    assign mode_legal = (mode != 2'd3);
    // Taps only matter when the LFSR is built; keep the parameter referenced.
    logic unused_taps;
    assign unused_taps = ^LFSR_TAPS;
`endif

    // Pattern value for word 0, from the live inputs on the start edge.
    always_comb begin
        first_word = seed;
        case (mode)
            2'd0:    first_word = DATA_W'(start_addr);
            2'd1:    first_word = seed;
            2'd2:    first_word = seed;
`ifdef MEM_FILL_LFSR_EN
            2'd3:    first_word = (seed == '0) ? DATA_W'(1) : seed;
`endif
            default: first_word = seed;
        endcase
    end

    // Pattern value following the word currently presented.
    always_comb begin
        next_word = data_q;
        case (mode_q)
            2'd0:    next_word = DATA_W'(addr_inc);
            2'd1:    next_word = data_q;
            2'd2:    next_word = data_q + step_q;
`ifdef MEM_FILL_LFSR_EN
            2'd3:    next_word = {data_q[DATA_W-2:0], ^(data_q & LFSR_TAPS)};
`endif
            default: next_word = data_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        data_d  = data_q;
        step_d  = step_q;
        mode_d  = mode_q;
        wren_d  = wren_q;
        rdy_d   = rdy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // rdy is always 1 in IDLE, including the done cycle, so a
                // held en restarts on the same edge that clears done.
                if (en && mode_legal) begin
                    state_d = S_FILL;
                    addr_d  = start_addr;
                    end_d   = end_addr;
                    data_d  = first_word;
                    step_d  = step;
                    mode_d  = mode;
                    wren_d  = 1'b1;
                    rdy_d   = 1'b0;
                end
            end
            S_FILL: begin
                if (!stall) begin
                    // The last word is the one at end_addr; comparing
                    // addresses avoids a separate N+1-bit word counter.
                    if (addr_q == end_q) begin
                        state_d = S_IDLE;
                        addr_d  = '0;
                        data_d  = '0;
                        wren_d  = 1'b0;
                        rdy_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_inc;
                        data_d = next_word;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                data_d  = '0;
                wren_d  = 1'b0;
                rdy_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            data_q  <= '0;
            step_q  <= '0;
            mode_q  <= '0;
            wren_q  <= 1'b0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            data_q  <= data_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            wren_q  <= wren_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
        end
    end

    assign addr   = addr_q;
    assign wrdata = data_q;
    assign wren   = wren_q;
    assign rdy    = rdy_q;
    assign done   = done_q;

endmodule

// File: doc/mem_fill.md
# mem_fill

Parametrised memory initialiser, the successor to the fixed 256-entry identity `init` engine. On an `en` request it writes a programmed address range, with wrap-around allowed, into a single-port RAM at one word per accepted cycle. The data pattern is identity, constant, ramp or (optionally) LFSR. It sits between the control FSM and the RAM write port, and honours a `stall` backpressure input from the RAM arbiter.

## Interface
- `ADDR_W`, default 8: address width; range wraps modulo 2^ADDR_W.
- `DATA_W`, default 8: data width.
- `LFSR_TAPS`, default 8'hB8: tap mask for LFSR mode, width DATA_W.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `en` in 1: start request; sampled only when `rdy`=1.
- `mode` in 2: 0 IDENTITY, 1 CONST, 2 RAMP, 3 LFSR; latched at start.
- `start_addr` in ADDR_W: first address; latched at start.
- `end_addr` in ADDR_W: last address, inclusive; latched at start.
- `seed` in DATA_W: constant, ramp origin or LFSR seed; latched at start.
- `step` in DATA_W: ramp increment; latched at start.
- `stall` in 1: 1 means the current write is not accepted.
- `rdy` out 1: idle and able to accept `en`.
- `done` out 1: one-cycle pulse when the fill completes.
- `addr` out ADDR_W: RAM write address.
- `wrdata` out DATA_W: RAM write data.
- `wren` out 1: write strobe.

## Operation
- States: IDLE and FILL. DONE is a one-cycle pass-through back to IDLE.
- Reset values: `rdy`=1, `done`=0, `wren`=0, `addr`=0, `wrdata`=0. Reset is asserted asynchronously at any time, including mid-fill, and aborts the fill immediately.
- IDLE to FILL:
  - Occurs on a rising edge with `en`=1 and `rdy`=1 and a legal mode.
  - All operands are latched on that edge.
  - Later changes to `mode`, `start_addr`, `end_addr`, `seed` and `step` have no effect until the next start.
- Word count is N = ((end_addr - start_addr) mod 2^ADDR_W) + 1.
  - `start_addr`=`end_addr` gives exactly 1 word.
  - `end_addr` < `start_addr` wraps past 2^ADDR_W-1 to 0.
- Data for word k (k = 0..N-1), all arithmetic modulo 2^DATA_W:
  - IDENTITY: `addr` zero-extended or truncated to DATA_W.
  - CONST: `seed`.
  - RAMP: `seed` + k*`step`, computed as a running sum (no multiplier).
  - LFSR: word 0 is `seed`, with a seed of 0 forced to 1. Each next word is {w[DATA_W-2:0], ^(w & LFSR_TAPS)}.
- In FILL, `wren`=1 every cycle. A write is accepted on an edge where `stall`=0.
- On an accepted write, `addr` advances by 1 (wrapping) and `wrdata` advances to the next pattern value.
- When `stall`=1, `addr`, `wrdata` and `wren` hold their values.
- After the last word is accepted, the next cycle shows `wren`=0, `rdy`=1, `done`=1, `addr`=0 and `wrdata`=0. `done` returns to 0 on the following cycle.
- `en` while `rdy`=0 is ignored. No queueing.
- `en` held high at completion restarts on the first edge at which `rdy`=1, so `done` and the new start coincide.

## Timing
- Start latency: the first write (`wren`=1, `addr`=`start_addr`) appears in the cycle after the `en` sampling edge.
- Throughput: 1 word per cycle with no stall, so a fill takes N cycles in FILL.
- End to end, with no stall, from the `en` edge to `done`=1 is N+1 edges.
- Each stalled cycle adds exactly 1 cycle.
- `stall` is sampled only in FILL. It is ignored in IDLE and in the `done` cycle.
- All outputs are registered. There is no combinational path from an input to any output.

## Configuration
- `MEM_FILL_LFSR_EN` defined: LFSR mode (mode 3) is built as described above.
- `MEM_FILL_LFSR_EN` undefined:
  - No LFSR logic is built.
  - `en` with `mode`=3 is ignored: `rdy` stays 1 and no write or `done` occurs.
  - Modes 0-2 are unaffected.

## Test plan
- Reset, then identity full range (ADDR_W=DATA_W=8, start 0, end 255): `rdy`=1 and outputs 0 after reset. Writes 0..255 with `wrdata`=`addr` on 256 consecutive cycles, then `done` pulses with `addr`=`wrdata`=0 and `rdy`=1.
- RAMP (start 10, end 13, seed 5, step 3): addr/data pairs 10/5, 11/8, 12/11, 13/14, then `done`. Also step 100 from seed 200 wraps to data 200, 44, 144.
- Wrap plus CONST (start 254, end 1, seed 8'hA5): addresses 254, 255, 0, 1, all with data A5, then `done`.
- Stall (identity, start 0, end 3, `stall`=1 for 2 cycles while at addr 1): addr 1 held for 3 cycles with `wren`=1; `done` arrives 2 cycles later than the unstalled case.
- Reset mid-fill at addr 100: on the same edge all outputs return to reset values with no `done`. A new `en` then restarts cleanly from the new `start_addr`.
- LFSR (seed 1, taps B8, start 0, end 4):
  - With the macro: data 01, 02, 04, 08, 11.
  - Without the macro: `en` with `mode`=3 leaves `rdy`=1 and `wren`=0.
